// File: rtl/rand_layer_pkg.sv
// Shared constants, FSM encoding and the xorshift32 step for rand_layer.
// Provides HID_DIM/N_LEN/SEED defaults plus xs32_step(state) -> next state.
package rand_layer_pkg;

    localparam int          HID_DIM_DEF = 24;
    localparam int          N_LEN_DEF   = 16;
    localparam logic [31:0] SEED_DEF    = 32'd2463534242;

    typedef enum logic [1:0] {
        S_IDLE,
        S_GEN,
        S_DONE
    } state_e;

    function automatic logic [31:0] xs32_step(input logic [31:0] s);
        logic [31:0] t;
        t = s;
        t = t ^ (t << 13);
        t = t ^ (t >> 17);
        t = t ^ (t << 5);
        return t;
    endfunction

endpackage

// File: rtl/xorshift32.sv
// xorshift32 generator (13/17/5): state register plus next-state logic.
// Ports: clk, rst_n (sync, active high), en (advance), seed, x (next state).
module xorshift32
    import rand_layer_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [31:0] seed,
    output logic [31:0] x
);

    logic [31:0] state_q;

    // x is the value the state takes on the next enabled edge, so the
    // consumer can store the freshly generated element on that same edge.
    assign x = xs32_step(state_q);

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q <= seed;
        end else if (en) begin
            state_q <= x;
        end
    end

endmodule

// File: rtl/rand_layer.sv
// Pseudo-random latent generator: fills HID_DIM slots of N_LEN bits from xorshift32.
// Ports: clk, rst_n (sync, active high), run (level request), valid, q (packed slots).
module rand_layer
    import rand_layer_pkg::*;
#(
    parameter int          HID_DIM = HID_DIM_DEF,
    parameter int          N_LEN   = N_LEN_DEF,
    parameter logic [31:0] SEED    = SEED_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     run,
    output logic                     valid,
    output logic [HID_DIM*N_LEN-1:0] q
);

    localparam int IDX_W = (HID_DIM > 1) ? $clog2(HID_DIM) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(HID_DIM - 1);

    state_e                   state_q;
    logic [IDX_W-1:0]         idx_q;
    logic [HID_DIM*N_LEN-1:0] q_q;
    logic                     valid_q;
    logic [31:0]              rnd;
    logic                     gen_en;

    // The generator only advances on edges that actually store a slot,
    // so an abort leaves the sequence exactly where writing stopped.
    assign gen_en = (state_q == S_GEN) && run;

    xorshift32 u_xs (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (gen_en),
        .seed  (SEED),
        .x     (rnd)
    );

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            q_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (run) begin
                        state_q <= S_GEN;
                        idx_q   <= '0;
                    end
                end
                S_GEN: begin
                    if (!run) begin
                        state_q <= S_IDLE;
                    end else begin
                        q_q[idx_q*N_LEN +: N_LEN] <= rnd[N_LEN-1:0];
                        if (idx_q == LAST) begin
                            state_q <= S_DONE;
                            idx_q   <= '0;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (run) begin
                        valid_q <= 1'b1;
                    end else begin
                        valid_q <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign valid = valid_q;
    assign q     = q_q;

endmodule

// File: tb/tb_rand_layer.sv
// Directed testbench for rand_layer with an xorshift32 reference model.
// Drives clk/rst_n/run and checks valid and q against expected vectors.
module tb_rand_layer;

    localparam int HD = 24;
    localparam int NL = 16;
    localparam int W  = HD * NL;
    localparam logic [31:0] SEED = 32'd2463534242;

    logic         clk;
    logic         rst_n;
    logic         run;
    logic         valid;
    logic [W-1:0] q;

    int tests;
    int fails;

    logic [31:0]  mst;
    logic [W-1:0] exp_q;
    logic [W-1:0] first_q;
    logic [W-1:0] old_q;

    rand_layer #(
        .HID_DIM (HD),
        .N_LEN   (NL),
        .SEED    (SEED)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (run),
        .valid (valid),
        .q     (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mstep(input logic [31:0] s);
        logic [31:0] t;
        t = s ^ (s << 13);
        t = t ^ (t >> 17);
        t = t ^ (t << 5);
        return t;
    endfunction

    // Advance the model n times, writing slots 0..n-1 of exp_q.
    task automatic model_vec(input int n);
        for (int i = 0; i < n; i++) begin
            mst = mstep(mst);
            exp_q[i*NL +: NL] = mst[NL-1:0];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        run   = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        tests++;
        if (valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_valid: got %b want 0", valid);
        end
        tests++;
        if (q !== '0) begin
            fails++;
            $display("FAIL reset_q: got %h want 0", q);
        end
        tick();
        tests++;
        if (valid !== 1'b0 || q !== '0) begin
            fails++;
            $display("FAIL idle_hold: valid %b q %h want 0/0", valid, q);
        end
    endtask

    task automatic test_first_vector();
        int bad;
        mst = SEED;
        run = 1'b1;
        tick();
        bad = (valid !== 1'b0) ? 1 : 0;
        for (int e = 1; e <= HD; e++) begin
            tick();
            if (valid !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL first_latency: valid early on %0d edges want 0", bad);
        end
        tick();
        tests++;
        if (valid !== 1'b1) begin
            fails++;
            $display("FAIL first_valid: got %b want 1", valid);
        end
        model_vec(HD);
        first_q = exp_q;
        tests++;
        if (q[NL-1:0] !== 16'd19811) begin
            fails++;
            $display("FAIL first_slot0: got %0d want 19811", q[NL-1:0]);
        end
        tests++;
        if (q !== exp_q) begin
            fails++;
            $display("FAIL first_q: got %h want %h", q, exp_q);
        end
    endtask

    task automatic test_hold();
        int bad;
        bad = 0;
        for (int i = 0; i < 120; i++) begin
            tick();
            if (q !== first_q || valid !== 1'b1) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL hold: %0d cycles changed want 0", bad);
        end
    endtask

    task automatic test_rerun();
        int bad;
        run = 1'b0;
        tick();
        tests++;
        if (valid !== 1'b0 || q !== first_q) begin
            fails++;
            $display("FAIL rerun_drop: valid %b want 0, q kept %b", valid, q === first_q);
        end
        run = 1'b1;
        tick();
        bad = 0;
        for (int e = 1; e <= HD; e++) begin
            tick();
            if (valid !== 1'b0) bad++;
        end
        tick();
        tests++;
        if (bad != 0 || valid !== 1'b1) begin
            fails++;
            $display("FAIL rerun_latency: early %0d valid %b want 0/1", bad, valid);
        end
        model_vec(HD);
        tests++;
        if (q !== exp_q) begin
            fails++;
            $display("FAIL rerun_q: got %h want %h", q, exp_q);
        end
        tests++;
        if (q === first_q) begin
            fails++;
            $display("FAIL rerun_differs: got %h want not %h", q, first_q);
        end
    endtask

    task automatic test_abort();
        int bad;
        run = 1'b0;
        tick();
        old_q = q;
        run   = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) tick();
        run = 1'b0;
        tick();
        exp_q = old_q;
        model_vec(10);
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (valid !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL abort_valid: high on %0d cycles want 0", bad);
        end
        tests++;
        if (q !== exp_q) begin
            fails++;
            $display("FAIL abort_q: got %h want %h", q, exp_q);
        end
        run = 1'b1;
        tick();
        for (int e = 1; e <= HD; e++) tick();
        tick();
        model_vec(HD);
        tests++;
        if (valid !== 1'b1 || q !== exp_q) begin
            fails++;
            $display("FAIL abort_resume: valid %b q %h want 1 %h", valid, q, exp_q);
        end
    endtask

    task automatic test_reset_mid_gen();
        run = 1'b0;
        tick();
        run = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) tick();
        rst_n = 1'b1;
        tick();
        rst_n = 1'b0;
        tests++;
        if (q !== '0 || valid !== 1'b0) begin
            fails++;
            $display("FAIL midgen_reset: valid %b q %h want 0/0", valid, q);
        end
        tick();
        for (int e = 1; e <= HD; e++) tick();
        tick();
        mst = SEED;
        model_vec(HD);
        tests++;
        if (valid !== 1'b1 || q !== first_q) begin
            fails++;
            $display("FAIL midgen_replay: valid %b q %h want 1 %h", valid, q, first_q);
        end
    endtask

    task automatic test_reset_and_run();
        int bad;
        run = 1'b0;
        tick();
        rst_n = 1'b1;
        run   = 1'b1;
        tick();
        rst_n = 1'b0;
        tests++;
        if (valid !== 1'b0 || q !== '0) begin
            fails++;
            $display("FAIL rst_run_state: valid %b q %h want 0/0", valid, q);
        end
        bad = 0;
        for (int e = 0; e <= HD; e++) begin
            tick();
            if (valid !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL rst_run_priority: valid early on %0d edges want 0", bad);
        end
        tick();
        tests++;
        if (valid !== 1'b1 || q !== first_q) begin
            fails++;
            $display("FAIL rst_run_vec: valid %b q %h want 1 %h", valid, q, first_q);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b1;
        run   = 1'b0;
        mst   = SEED;
        exp_q = '0;
        first_q = '0;
        old_q = '0;
        test_reset();
        test_first_vector();
        test_hold();
        test_rerun();
        test_abort();
        test_reset_mid_gen();
        test_reset_and_run();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
